// File: rtl/status_write_seq_pkg.sv
// Shared types, constants and the status-byte encoder for the RTC status sequencers.
package rtc_status_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } seq_state_e;

    localparam logic [1:0] MODE_WRITE = 2'd3;

    localparam int DEF_FMT_BIT   = 4;
    localparam int DEF_CRONO_BIT = 3;

    typedef struct packed {
        logic a_a;
        logic f_h;
        logic crono;
    } status_flags_t;

    // Alarm acknowledge masks the chronometer flag; every other bit stays 0.
    function automatic logic [31:0] encode_status(
        input status_flags_t flags,
        input int            fmt_bit,
        input int            crono_bit
    );
        logic [31:0] res;
        res            = '0;
        res[fmt_bit]   = flags.f_h;
        res[crono_bit] = flags.crono & ~flags.a_a;
        return res;
    endfunction

endpackage

// File: rtl/status_write_seq_if.sv
// Controller-side bus of the status write sequencer: mode, flags, pacing ticks and the write outputs.
interface status_write_seq_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        Control;
    logic              A_A;
    logic              F_H;
    logic              act_crono;
    logic              enable_cont_16;
    logic              enable_cont_MS;
    logic [DATA_W-1:0] Mod_s;
    logic              Mod_addr;
    logic              Mod_busy;
    logic              Mod_done;

    modport master (
        output Control, A_A, F_H, act_crono, enable_cont_16, enable_cont_MS,
        input  Mod_s, Mod_addr, Mod_busy, Mod_done
    );

    modport slave (
        input  Control, A_A, F_H, act_crono, enable_cont_16, enable_cont_MS,
        output Mod_s, Mod_addr, Mod_busy, Mod_done
    );
endinterface

// File: rtl/status_write_seq_counter.sv
// phase_tick_counter: counts pacing ticks within a phase and flags the PHASE_TICKS-th one.
module phase_tick_counter #(
    parameter int PHASE_TICKS = 2
) (
    input  logic reloj,
    input  logic resetM,
    input  logic clr,
    input  logic tick,
    output logic last_tick
);

    localparam int                CNT_W    = $clog2(PHASE_TICKS) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PHASE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over tick, so the owner clears on the terminal tick and the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_tick = tick && (cnt_q == CNT_LAST);

endmodule

// File: rtl/status_write_seq.sv
// status_write_seq: in write mode, issues one status write (address phase, then data phase).
// Optional macro STATUS_CHANGE_ONLY_EN: start only on the first write or when the status changed.
module status_write_seq
    import rtc_status_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter logic [7:0] STATUS_ADDR = 8'h00,
    parameter int         PHASE_TICKS = 2,
    parameter int         FMT_BIT     = DEF_FMT_BIT,
    parameter int         CRONO_BIT   = DEF_CRONO_BIT
) (
    input  logic              reloj,
    input  logic              resetM,
    status_write_seq_if.slave bus
);

`ifdef STATUS_CHANGE_ONLY_EN
    localparam bit CHANGE_ONLY = 1'b1;
`else
    localparam bit CHANGE_ONLY = 1'b0;
`endif

    localparam logic [DATA_W-1:0] ADDR_VAL = DATA_W'(STATUS_ADDR);

    seq_state_e        state_q, state_d;
    status_flags_t     in_status_q, in_status_d;
    status_flags_t     snap_q, snap_d;
    status_flags_t     last_q, last_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] mod_s_q, mod_s_d;
    logic              mod_addr_q, mod_addr_d;
    logic              mod_busy_q, mod_busy_d;
    logic              mod_done_q, mod_done_d;

    logic tick;
    logic write_mode;
    logic in_phase;
    logic abort;
    logic status_changed;
    logic start_ok;
    logic cnt_clr;
    logic cnt_tick;
    logic last_tick;

    always_comb begin
        tick           = bus.enable_cont_16 & bus.enable_cont_MS;
        write_mode     = (bus.Control == MODE_WRITE);
        in_phase       = (state_q == S_ADDR) || (state_q == S_DATA);
        abort          = in_phase && !write_mode;
        status_changed = first_q || (in_status_q != last_q);
        start_ok       = status_changed || !CHANGE_ONLY;
        // A tick landing on the abort cycle must not be counted.
        cnt_tick       = tick && in_phase && !abort;
        cnt_clr        = !in_phase || abort || last_tick;
    end

    phase_tick_counter #(
        .PHASE_TICKS(PHASE_TICKS)
    ) u_phase_cnt (
        .reloj    (reloj),
        .resetM   (resetM),
        .clr      (cnt_clr),
        .tick     (cnt_tick),
        .last_tick(last_tick)
    );

    always_comb begin
        state_d     = state_q;
        in_status_d = {bus.A_A, bus.F_H, bus.act_crono};
        snap_d      = snap_q;
        last_d      = last_q;
        first_d     = first_q;

        unique case (state_q)
            S_IDLE: begin
                if (write_mode && tick && start_ok) begin
                    state_d = S_ADDR;
                    snap_d  = in_status_q;
                end
            end
            S_ADDR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_tick) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                last_d  = snap_q;
                first_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the registered state.
        mod_addr_d = (state_d == S_ADDR);
        mod_busy_d = (state_d == S_ADDR) || (state_d == S_DATA);
        mod_done_d = (state_d == S_DONE);
        mod_s_d    = '0;
        if (state_d == S_ADDR) begin
            mod_s_d = ADDR_VAL;
        end else if (state_d == S_DATA) begin
            mod_s_d = DATA_W'(encode_status(snap_d, FMT_BIT, CRONO_BIT));
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q     <= S_IDLE;
            in_status_q <= '0;
            snap_q      <= '0;
            last_q      <= '0;
            first_q     <= 1'b1;
            mod_s_q     <= '0;
            mod_addr_q  <= 1'b0;
            mod_busy_q  <= 1'b0;
            mod_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_status_q <= in_status_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            first_q     <= first_d;
            mod_s_q     <= mod_s_d;
            mod_addr_q  <= mod_addr_d;
            mod_busy_q  <= mod_busy_d;
            mod_done_q  <= mod_done_d;
        end
    end

    assign bus.Mod_s    = mod_s_q;
    assign bus.Mod_addr = mod_addr_q;
    assign bus.Mod_busy = mod_busy_q;
    assign bus.Mod_done = mod_done_q;

endmodule

// File: tb/tb_status_write_seq.sv
// Scoreboard bench for status_write_seq (PHASE_TICKS=2, DATA_W=8); follows STATUS_CHANGE_ONLY_EN if defined.
module tb_status_write_seq;

    typedef struct {
        logic [7:0] data;
        int         addr_cyc;
        int         data_cyc;
        bit         aborted;
    } txn_t;

    logic reloj;
    logic resetM;

    int errors = 0;
    int checks = 0;

    txn_t exp_q[$];

    status_write_seq_if #(.DATA_W(8)) bus ();

    status_write_seq #(
        .DATA_W     (8),
        .STATUS_ADDR(8'h00),
        .PHASE_TICKS(2),
        .FMT_BIT    (4),
        .CRONO_BIT  (3)
    ) dut (
        .reloj (reloj),
        .resetM(resetM),
        .bus   (bus)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    // Every comparison funnels through here so the counts stay in one place.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_mod_s"},    32'(bus.Mod_s),    32'h0);
        checkOutput({name, "_mod_addr"}, 32'(bus.Mod_addr), 32'h0);
        checkOutput({name, "_mod_busy"}, 32'(bus.Mod_busy), 32'h0);
        checkOutput({name, "_mod_done"}, 32'(bus.Mod_done), 32'h0);
    endtask

    task automatic expectTxn(input logic [7:0] data, input int a, input int d, input bit ab);
        txn_t t;
        t.data     = data;
        t.addr_cyc = a;
        t.data_cyc = d;
        t.aborted  = ab;
        exp_q.push_back(t);
    endtask

    // Flags are {A_A, F_H, act_crono}; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [1:0] ctrl, input logic [2:0] flags,
                                 input logic en16, input logic enms, input int n);
        bus.Control        = ctrl;
        bus.A_A            = flags[2];
        bus.F_H            = flags[1];
        bus.act_crono      = flags[0];
        bus.enable_cont_16 = en16;
        bus.enable_cont_MS = enms;
        repeat (n) begin
            @(posedge reloj);
            #1;
        end
    endtask

    // Monitor: rebuilds each transaction from the outputs and scores it when busy drops.
    bit         in_txn   = 1'b0;
    bit         prev_busy = 1'b0;
    bit         addr_ok;
    int         addr_cnt;
    int         data_cnt;
    logic [7:0] data_val;

    always @(negedge reloj) begin
        if (bus.Mod_done === 1'b1 && !prev_busy) begin
            checkOutput("stray_done", 32'(bus.Mod_done), 32'h0);
        end
        if (bus.Mod_busy === 1'b1) begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                addr_ok  = 1'b1;
                addr_cnt = 0;
                data_cnt = 0;
                data_val = 8'h00;
            end
            if (bus.Mod_addr === 1'b1) begin
                addr_cnt++;
                if (bus.Mod_s !== 8'h00) addr_ok = 1'b0;
            end else begin
                data_cnt++;
                data_val = bus.Mod_s;
            end
        end else if (in_txn) begin
            txn_t e;
            in_txn = 1'b0;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_txn", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("txn_done",      32'(bus.Mod_done), 32'(!e.aborted));
                checkOutput("txn_addr_cyc",  32'(addr_cnt),     32'(e.addr_cyc));
                checkOutput("txn_data_cyc",  32'(data_cnt),     32'(e.data_cyc));
                checkOutput("txn_data",      32'(data_val),     32'(e.data));
                checkOutput("txn_addr_byte", 32'(addr_ok),      32'd1);
                checkOutput("txn_end_mod_s", 32'(bus.Mod_s),    32'h0);
            end
        end
        prev_busy = (bus.Mod_busy === 1'b1);
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        resetM = 1'b1;
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b0, 2);
        checkIdle("reset");
        resetM = 1'b0;

        $display("[TB] basic write, flags 001");
        applyStimulus(2'd0, 3'b001, 1'b0, 1'b0, 3);
        expectTxn(8'h08, 2, 2, 1'b0);
        applyStimulus(2'd3, 3'b001, 1'b1, 1'b1, 5);
        applyStimulus(2'd0, 3'b001, 1'b0, 1'b0, 3);

        $display("[TB] flags 111 and 101");
        applyStimulus(2'd0, 3'b111, 1'b0, 1'b0, 3);
        expectTxn(8'h10, 2, 2, 1'b0);
        applyStimulus(2'd3, 3'b111, 1'b1, 1'b1, 5);
        applyStimulus(2'd0, 3'b101, 1'b0, 1'b0, 3);
        expectTxn(8'h00, 2, 2, 1'b0);
        applyStimulus(2'd3, 3'b101, 1'b1, 1'b1, 5);
        applyStimulus(2'd0, 3'b101, 1'b0, 1'b0, 3);

        $display("[TB] abort during data phase");
        applyStimulus(2'd0, 3'b010, 1'b0, 1'b0, 3);
        expectTxn(8'h10, 2, 1, 1'b1);
        applyStimulus(2'd3, 3'b010, 1'b1, 1'b1, 3);
        applyStimulus(2'd0, 3'b010, 1'b1, 1'b1, 1);
        checkIdle("abort");
        applyStimulus(2'd0, 3'b010, 1'b0, 1'b0, 3);

        $display("[TB] sparse ticks, one every 4 cycles");
        applyStimulus(2'd0, 3'b001, 1'b0, 1'b0, 3);
        expectTxn(8'h08, 8, 8, 1'b0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'd3, 3'b001, ((i % 2) == 0), ((i % 4) == 0), 1);
        end
        applyStimulus(2'd0, 3'b001, 1'b0, 1'b0, 3);

        $display("[TB] write mode held with steady flags");
        applyStimulus(2'd0, 3'b011, 1'b0, 1'b0, 3);
        expectTxn(8'h18, 2, 2, 1'b0);
`ifndef STATUS_CHANGE_ONLY_EN
        expectTxn(8'h18, 2, 2, 1'b0);
        expectTxn(8'h18, 2, 2, 1'b0);
`endif
        applyStimulus(2'd3, 3'b011, 1'b1, 1'b1, 18);
        applyStimulus(2'd0, 3'b010, 1'b0, 1'b0, 3);
        expectTxn(8'h10, 2, 2, 1'b0);
`ifndef STATUS_CHANGE_ONLY_EN
        expectTxn(8'h10, 2, 2, 1'b0);
`endif
        applyStimulus(2'd3, 3'b010, 1'b1, 1'b1, 12);
        applyStimulus(2'd0, 3'b010, 1'b0, 1'b0, 3);

        $display("[TB] reset during address phase");
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b0, 3);
        expectTxn(8'h00, 1, 0, 1'b1);
        applyStimulus(2'd3, 3'b000, 1'b1, 1'b1, 1);
        resetM = 1'b1;
        applyStimulus(2'd3, 3'b000, 1'b1, 1'b1, 1);
        checkIdle("reset_mid");
        resetM = 1'b0;
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b0, 2);
        expectTxn(8'h00, 2, 2, 1'b0);
        applyStimulus(2'd3, 3'b000, 1'b1, 1'b1, 5);
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b0, 5);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
